// File: rtl/seven_seg_pkg.sv
// Shared constants, control-word field positions and FSM encoding for the
// seven-segment display controller.
package seven_seg_pkg;

  // Active-low pattern with every segment and the dp off.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  // Glyph '0' with dp off; the power-up content of the pattern banks.
  localparam logic [7:0] SEG_ZERO  = 8'hC0;

  // Write-port register map; addresses 2 and 3 are reserved.
  localparam logic [1:0] ADDR_VALUE = 2'd0;
  localparam logic [1:0] ADDR_CTRL  = 2'd1;

  // Control-word field positions.
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_LZB_BIT   = 1;
  localparam int CTRL_BLINK_BIT = 2;
  localparam int CTRL_DP_LSB    = 8;
  localparam int CTRL_BLINK_LSB = 16;

  // Control word after reset: display enabled, everything else off.
  localparam logic [31:0] CTRL_RESET = 32'h0000_0001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // Extend a 7-bit glyph to a full pattern with the dp segment off.
  function automatic logic [7:0] glyph_to_pattern(input logic [6:0] glyph);
    return {1'b1, glyph};
  endfunction

endpackage

// File: rtl/seven_seg_ctrl_hex_to_sseg.sv
// Combinational hex nibble to active-low seven-segment glyph (bits g..a).
module hex_to_sseg (
  input  logic [3:0] nibble_i,
  output logic [6:0] sseg_o
);

  // Glyph lookup for 0..F.
  always_comb begin
    sseg_o = 7'h7F;
    case (nibble_i)
      4'h0:    sseg_o = 7'h40;
      4'h1:    sseg_o = 7'h79;
      4'h2:    sseg_o = 7'h24;
      4'h3:    sseg_o = 7'h30;
      4'h4:    sseg_o = 7'h19;
      4'h5:    sseg_o = 7'h12;
      4'h6:    sseg_o = 7'h02;
      4'h7:    sseg_o = 7'h78;
      4'h8:    sseg_o = 7'h00;
      4'h9:    sseg_o = 7'h10;
      4'hA:    sseg_o = 7'h08;
      4'hB:    sseg_o = 7'h03;
      4'hC:    sseg_o = 7'h46;
      4'hD:    sseg_o = 7'h21;
      4'hE:    sseg_o = 7'h06;
      4'hF:    sseg_o = 7'h0E;
      default: sseg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seven_seg_ctrl.sv
// 8-digit seven-segment display controller. A CPU writes a 32-bit hex value
// or a control word; the eight nibbles are then encoded one per cycle
// through a single shared decoder into a shadow bank, and the whole bank is
// committed to the displayed base patterns in one cycle so the display never
// shows a half-updated value. Enable, dp and blink are applied in the
// registered output stage.
module seven_seg_ctrl
  import seven_seg_pkg::*;
#(
  parameter int BLINK_BITS = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        busy,
  output logic [7:0]  seg0,
  output logic [7:0]  seg1,
  output logic [7:0]  seg2,
  output logic [7:0]  seg3,
  output logic [7:0]  seg4,
  output logic [7:0]  seg5,
  output logic [7:0]  seg6,
  output logic [7:0]  seg7
);

  state_e                 state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic                   seen_q, seen_d;
  logic [31:0]            value_q, value_d;
  logic                   en_q, en_d;
  logic                   lzb_q, lzb_d;
  logic                   blink_en_q, blink_en_d;
  logic [7:0]             dp_mask_q, dp_mask_d;
  logic [7:0]             blink_mask_q, blink_mask_d;
  logic [7:0][7:0]        shadow_q, shadow_d;
  logic [7:0][7:0]        base_q, base_d;
  logic [7:0][7:0]        seg_q, seg_d;
  logic [BLINK_BITS-1:0]  blink_cnt_q, blink_cnt_d;

  logic                   accept_s;
  logic [3:0]             nibble_s;
  logic [6:0]             glyph_s;
  logic                   blink_phase_s;

  assign wr_ready      = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign accept_s      = wr_valid && wr_ready;
  assign nibble_s      = value_q[{idx_q, 2'b00} +: 4];
  assign blink_phase_s = blink_cnt_q[BLINK_BITS-1];

  hex_to_sseg u_hex (
    .nibble_i (nibble_s),
    .sseg_o   (glyph_s)
  );

  // Register writes, encode sequencing and atomic commit.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    seen_d       = seen_q;
    value_d      = value_q;
    en_d         = en_q;
    lzb_d        = lzb_q;
    blink_en_d   = blink_en_q;
    dp_mask_d    = dp_mask_q;
    blink_mask_d = blink_mask_q;
    shadow_d     = shadow_q;
    base_d       = base_q;
    case (state_q)
      IDLE: begin
        if (accept_s && (wr_addr == ADDR_VALUE)) begin
          value_d = wr_data;
          state_d = ENCODE;
          idx_d   = 3'd7;
          seen_d  = 1'b0;
        end else if (accept_s && (wr_addr == ADDR_CTRL)) begin
          en_d         = wr_data[CTRL_EN_BIT];
          lzb_d        = wr_data[CTRL_LZB_BIT];
          blink_en_d   = wr_data[CTRL_BLINK_BIT];
          dp_mask_d    = wr_data[CTRL_DP_LSB +: 8];
          blink_mask_d = wr_data[CTRL_BLINK_LSB +: 8];
          state_d      = ENCODE;
          idx_d        = 3'd7;
          seen_d       = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      ENCODE: begin
        // Leading zeros blank only until the first non-zero digit; digit 0
        // always shows so a zero value still reads "0".
        if (lzb_q && !seen_q && (nibble_s == 4'h0) && (idx_q != 3'd0)) begin
          shadow_d[idx_q] = SEG_BLANK;
        end else begin
          shadow_d[idx_q] = glyph_to_pattern(glyph_s);
        end
        seen_d = seen_q || (nibble_s != 4'h0);
        if (idx_q == 3'd0) begin
          state_d = COMMIT;
        end else begin
          idx_d = idx_q - 3'd1;
        end
      end
      COMMIT: begin
        base_d  = shadow_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Free-running blink counter, wraps naturally.
  always_comb begin
    blink_cnt_d = blink_cnt_q + {{(BLINK_BITS-1){1'b0}}, 1'b1};
  end

  // Per-digit output pattern: enable, blink, then dp over the base glyph.
  always_comb begin
    seg_d = {8{SEG_BLANK}};
    for (int n = 0; n < 8; n++) begin
      if (!en_q) begin
        seg_d[n] = SEG_BLANK;
      end else if (blink_en_q && blink_mask_q[n] && blink_phase_s) begin
        seg_d[n] = SEG_BLANK;
      end else begin
        seg_d[n] = {~dp_mask_q[n], base_q[n][6:0]};
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= 3'd7;
      seen_q       <= 1'b0;
      value_q      <= 32'h0000_0000;
      en_q         <= CTRL_RESET[CTRL_EN_BIT];
      lzb_q        <= CTRL_RESET[CTRL_LZB_BIT];
      blink_en_q   <= CTRL_RESET[CTRL_BLINK_BIT];
      dp_mask_q    <= CTRL_RESET[CTRL_DP_LSB +: 8];
      blink_mask_q <= CTRL_RESET[CTRL_BLINK_LSB +: 8];
      shadow_q     <= {8{SEG_ZERO}};
      base_q       <= {8{SEG_ZERO}};
      seg_q        <= {8{SEG_BLANK}};
      blink_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      seen_q       <= seen_d;
      value_q      <= value_d;
      en_q         <= en_d;
      lzb_q        <= lzb_d;
      blink_en_q   <= blink_en_d;
      dp_mask_q    <= dp_mask_d;
      blink_mask_q <= blink_mask_d;
      shadow_q     <= shadow_d;
      base_q       <= base_d;
      seg_q        <= seg_d;
      blink_cnt_q  <= blink_cnt_d;
    end
  end

  assign seg0 = seg_q[0];
  assign seg1 = seg_q[1];
  assign seg2 = seg_q[2];
  assign seg3 = seg_q[3];
  assign seg4 = seg_q[4];
  assign seg5 = seg_q[5];
  assign seg6 = seg_q[6];
  assign seg7 = seg_q[7];

endmodule

// File: tb/tb_seven_seg_ctrl.sv
// Directed self-checking bench for seven_seg_ctrl (blink counter shortened
// to 4 bits so blinking is observable).
module tb_seven_seg_ctrl;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic [7:0]  seg [8];

  int total = 0;
  int bad   = 0;
  int acc_cnt = 0;

  seven_seg_ctrl #(.BLINK_BITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .seg0     (seg[0]),
    .seg1     (seg[1]),
    .seg2     (seg[2]),
    .seg3     (seg[3]),
    .seg4     (seg[4]),
    .seg5     (seg[5]),
    .seg6     (seg[6]),
    .seg7     (seg[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted writes as seen on the rising edge.
  always @(posedge clk) begin
    if (wr_valid && wr_ready && !rst) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Compare all eight digits; e[n] is the expected pattern of digit n.
  task automatic check_segs(input string tag, input logic [63:0] e);
    for (int n = 0; n < 8; n++) begin
      check($sformatf("%s_seg%0d", tag, n), {24'h0, seg[n]}, {24'h0, e[8*n +: 8]});
    end
  endtask

  // Issue one write starting at a negedge; returns at the negedge after acceptance.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    while (!wr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("wr_timeout", 32'd0, 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Wait until the encode sequence ends, then one more cycle for the outputs.
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] first;
    logic [7:0] other;
    int         n;
    int         run_err;
    int         steady_err;
    int         rdy_err;
    int         acc0;

    rst = 1'b1; wr_valid = 1'b0; wr_addr = 2'd0; wr_data = 32'h0;
    repeat (3) @(negedge clk);
    check_segs("in_reset", {8{8'hFF}});
    rst = 1'b0;
    check_segs("rel", {8{8'hFF}});
    check("rel_ready", {31'h0, wr_ready}, 32'd1);
    check("rel_busy", {31'h0, busy}, 32'd0);
    @(negedge clk);
    check_segs("post_rst", {8{8'hC0}});

    // Leading-zero blanking.
    wr(2'd0, 32'h0000_12AF); wait_idle();
    wr(2'd1, 32'h0000_0003); wait_idle();
    check_segs("lzb", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'h88, 8'h8E});
    wr(2'd0, 32'h0000_0000); wait_idle();
    check_segs("lzb_zero", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});

    // Handshake timing with a second write held valid during busy.
    acc0 = acc_cnt;
    check("t_ready0", {31'h0, wr_ready}, 32'd1);
    wr_valid = 1'b1; wr_addr = 2'd1; wr_data = 32'h0000_0001;
    @(negedge clk);
    wr_addr = 2'd0; wr_data = 32'h7654_3210;
    for (int k = 0; k < 9; k++) begin
      check($sformatf("t_ready_low%0d", k), {31'h0, wr_ready}, 32'd0);
      @(negedge clk);
    end
    check("t_ready_high", {31'h0, wr_ready}, 32'd1);
    check("t_lat_early", {24'h0, seg[7]}, 32'h0000_00FF);
    @(negedge clk);
    wr_valid = 1'b0;
    check("t_lat_new", {24'h0, seg[7]}, 32'h0000_00C0);
    check("t_b_accepted", {31'h0, wr_ready}, 32'd0);
    wait_idle();
    repeat (12) @(negedge clk);
    check("t_accepts", acc_cnt - acc0, 32'd2);
    check_segs("t_b_value", {8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0});

    // Decimal points and disable latency.
    wr(2'd0, 32'h8888_8888); wait_idle();
    wr(2'd1, 32'h0000_0501); wait_idle();
    check_segs("dp", {8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h80, 8'h00});
    wr(2'd1, 32'h0000_0000);
    check("dis_old", {24'h0, seg[0]}, 32'h0000_0000);
    @(negedge clk);
    check_segs("dis", {8{8'hFF}});
    wait_idle();

    // Blink on digit 0 only.
    wr(2'd1, 32'h0001_0005); wait_idle();
    first = seg[0];
    n = 0;
    while (seg[0] == first && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("blink_toggles", {31'h0, (n < 20)}, 32'd1);
    first = seg[0];
    check("blink_val", {31'h0, (first == 8'hFF || first == 8'h80)}, 32'd1);
    other = (first == 8'hFF) ? 8'h80 : 8'hFF;
    run_err = 0; steady_err = 0;
    for (int i = 0; i < 16; i++) begin
      if (seg[0] !== ((i < 8) ? first : other)) run_err++;
      for (int d = 1; d < 8; d++) if (seg[d] !== 8'h80) steady_err++;
      @(negedge clk);
    end
    check("blink_runs", run_err, 32'd0);
    check("blink_steady", steady_err, 32'd0);

    // Reserved address: no sequence, nothing changes.
    wr(2'd1, 32'h0000_0001); wait_idle();
    wr(2'd2, 32'hFFFF_FFFF);
    rdy_err = 0;
    for (int i = 0; i < 12; i++) begin
      if (wr_ready !== 1'b1 || busy !== 1'b0) rdy_err++;
      @(negedge clk);
    end
    check("rsvd_ready", rdy_err, 32'd0);
    check_segs("rsvd", {8{8'h80}});

    // Reset in the 4th encode cycle.
    wr(2'd0, 32'h1234_5678);
    repeat (3) @(negedge clk);
    check("mid_busy", {31'h0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_segs("mid_rst", {8{8'hFF}});
    check("mid_ready", {31'h0, wr_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_segs("mid_post", {8{8'hC0}});
    repeat (12) @(negedge clk);
    check_segs("mid_nocommit", {8{8'hC0}});
    check("mid_idle", {31'h0, busy}, 32'd0);
    wr(2'd1, 32'h0000_0003); wait_idle();
    check_segs("mid_value0", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
